// File: rtl/eject_merge_2subnet_pkg.sv
// rtl/eject_merge_2subnet_pkg.sv - shared constants and helpers for the ejection merge stage
//
// Purpose: default flit width, valid-bit position and queue depth, plus the
//          saturating drop-counter adder used by the top level.
// Ports:   none (package).
package eject_merge_2subnet_pkg;

  // Router port word width and the index of its flit-valid flag.
  localparam int EJ_WIDTH_PORT = 32;
  localparam int EJ_VALID_BIT  = EJ_WIDTH_PORT - 1;

  // Default ejection queue depth.
  localparam int EJ_DEPTH = 8;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Adds 0..2 to a 16-bit counter, clamping at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? DROP_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/eject_merge_2subnet_fifo_2w1r.sv
// rtl/eject_merge_2subnet_fifo_2w1r.sv - dual-write single-read circular buffer
//
// Purpose: stores up to DEPTH words; up to two ordered writes and one read per cycle.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wr_en1, wr_data1    first (earlier) write slot
//   wr_en2, wr_data2    second write slot, lands after wr_data1 when both are enabled
//   rd_en               remove head (caller guarantees non-empty)
//   head                word at the read pointer (storage-read mux)
//   not_empty           registered non-empty flag
//   occupancy           registered entry count, 0..DEPTH
// The caller guarantees writes never exceed the free space.
module fifo_2w1r
  import eject_merge_2subnet_pkg::*;
#(
  parameter int WIDTH = EJ_WIDTH_PORT,
  parameter int DEPTH = EJ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en1,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic             wr_en2,
  input  logic [WIDTH-1:0] wr_data2,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic [AW:0]      occupancy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr2;
  logic [AW:0]      occ_next;

  // Second slot sits directly after the first only when the first is used too.
  assign wr_ptr2  = wr_ptr + AW'(wr_en1);
  assign occ_next = occupancy + (AW+1)'(wr_en1) + (AW+1)'(wr_en2) - (AW+1)'(rd_en);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      not_empty <= 1'b0;
    end else begin
      if (wr_en1) mem[wr_ptr]  <= wr_data1;
      if (wr_en2) mem[wr_ptr2] <= wr_data2;
      wr_ptr    <= wr_ptr + AW'(wr_en1) + AW'(wr_en2);
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      occupancy <= occ_next;
      not_empty <= (occ_next != '0);
    end
  end

endmodule

// File: rtl/eject_merge_2subnet.sv
// rtl/eject_merge_2subnet.sv - merges both subnets' ejected flits into one core-facing queue
//
// Purpose: captures valid local-output flits of both routers every cycle, queues them
//          subnet 1 first, drops what does not fit, counts drops and flags overflow.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ejIn1, ejIn2        subnet local output words; flit present when bit VALID_BIT is set
//   coreFlit            head-of-queue word (unmodified)
//   coreValid           queue non-empty
//   coreReady           core takes the head this cycle
//   occupancy           entries held
//   dropCnt             saturating count of dropped flits
//   overflow            sticky, set on first drop
module eject_merge_2subnet
  import eject_merge_2subnet_pkg::*;
#(
  parameter int WIDTH_PORT = EJ_WIDTH_PORT,
  parameter int VALID_BIT  = WIDTH_PORT - 1,
  parameter int DEPTH      = EJ_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH_PORT-1:0] ejIn1,
  input  logic [WIDTH_PORT-1:0] ejIn2,
  output logic [WIDTH_PORT-1:0] coreFlit,
  output logic                  coreValid,
  input  logic                  coreReady,
  output logic [AW:0]           occupancy,
  output logic [15:0]           dropCnt,
  output logic                  overflow
);

  logic          arr1;
  logic          arr2;
  logic          pop;
  logic [AW+1:0] free;
  logic          wr1;
  logic          wr2;
  logic [1:0]    dropped;

  assign arr1 = ejIn1[VALID_BIT];
  assign arr2 = ejIn2[VALID_BIT];
  assign pop  = coreValid & coreReady;

  // A same-cycle pop frees a slot for an arrival; this is the only
  // combinational input-to-state dependency.
  assign free = (AW+2)'(DEPTH) - {1'b0, occupancy} + (AW+2)'(pop);

  // Subnet 1 takes the first free slot; subnet 2 needs a second one only
  // when subnet 1 also arrived.
  always_comb begin
    wr1 = 1'b0;
    wr2 = 1'b0;
    if (arr1 && free >= (AW+2)'(1)) wr1 = 1'b1;
    if (arr2 && free >= (arr1 ? (AW+2)'(2) : (AW+2)'(1))) wr2 = 1'b1;
  end

  assign dropped = {1'b0, arr1 & ~wr1} + {1'b0, arr2 & ~wr2};

  fifo_2w1r #(
    .WIDTH (WIDTH_PORT),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en1    (wr1),
    .wr_data1  (ejIn1),
    .wr_en2    (wr2),
    .wr_data2  (ejIn2),
    .rd_en     (pop),
    .head      (coreFlit),
    .not_empty (coreValid),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropCnt  <= '0;
      overflow <= 1'b0;
    end else if (dropped != 2'd0) begin
      dropCnt  <= sat_add16(dropCnt, dropped);
      overflow <= 1'b1;
    end
  end

endmodule
